// File: rtl/hilo_muldiv_pkg.sv
// Shared op codes, divider state encoding and small helpers for the HI/LO unit.
package hilo_muldiv_pkg;

  // Decode op codes seen in EX that concern the HI/LO unit.
  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;

  // Divider sequencing states.
  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_ON   = 2'b01,
    DIV_END  = 2'b10
  } div_state_e;

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

  // Magnitude of a value; only negative values of a signed operation are flipped.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// EX-stage bundle between the pipeline (master) and the HI/LO unit (slave).
interface hilo_muldiv_if;
  logic [7:0]  alucontrolE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic        flushE;
  logic        div_stall;
  logic [31:0] hilo_rdata;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output alucontrolE, srcaE, srcbE, flushE,
    input  div_stall, hilo_rdata, hi_o, lo_o
  );

  modport slave (
    input  alucontrolE, srcaE, srcbE, flushE,
    output div_stall, hilo_rdata, hi_o, lo_o
  );
endinterface

// File: rtl/hilo_muldiv_div_radix2.sv
// Radix-2 restoring divider: one quotient bit per cycle over 32 cycles on
// magnitudes, with sign fix-up and divide-by-zero override applied at the output.
module div_radix2
  import hilo_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        signed_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  div_state_e  state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [63:0] sr_q, sr_d;          // {remainder, quotient} shift register
  logic [31:0] divisor_q, divisor_d;
  logic [31:0] a_raw_q, a_raw_d;    // dividend as issued, returned on divide by zero
  logic        neg_quot_q, neg_quot_d;
  logic        neg_rem_q, neg_rem_d;
  logic        bzero_q, bzero_d;

  logic [63:0] shifted_s;
  logic [32:0] diff_s;
  logic [63:0] sr_iter_s;

  // One restoring step: shift left, trial-subtract, keep the difference if it did not borrow.
  always_comb begin
    shifted_s = {sr_q[62:0], 1'b0};
    diff_s    = {1'b0, shifted_s[63:32]} - {1'b0, divisor_q};
    if (!diff_s[32]) begin
      sr_iter_s = {diff_s[31:0], shifted_s[31:1], 1'b1};
    end else begin
      sr_iter_s = shifted_s;
    end
  end

  // Next-state and datapath load/iterate decisions.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    sr_d       = sr_q;
    divisor_d  = divisor_q;
    a_raw_d    = a_raw_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    bzero_d    = bzero_q;
    case (state_q)
      DIV_IDLE: begin
        if (start_i) begin
          state_d    = DIV_ON;
          count_d    = 5'd0;
          sr_d       = {32'd0, abs32(a_i, signed_i)};
          divisor_d  = abs32(b_i, signed_i);
          a_raw_d    = a_i;
          neg_quot_d = signed_i & (a_i[31] ^ b_i[31]);
          neg_rem_d  = signed_i & a_i[31];
          bzero_d    = (b_i == 32'd0);
        end else begin
          state_d = DIV_IDLE;
        end
      end
      DIV_ON: begin
        if (abort_i) begin
          state_d = DIV_IDLE;
          count_d = 5'd0;
        end else begin
          sr_d    = sr_iter_s;
          count_d = count_q + 5'd1;
          if (count_q == 5'd31) begin
            state_d = DIV_END;
          end else begin
            state_d = DIV_ON;
          end
        end
      end
      DIV_END: begin
        // The issuing op is still in EX here; always return to idle so it cannot restart.
        state_d = DIV_IDLE;
        count_d = 5'd0;
      end
      default: begin
        state_d = DIV_IDLE;
        count_d = 5'd0;
      end
    endcase
  end

  // Divider state, counter and operand registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DIV_IDLE;
      count_q    <= 5'd0;
      sr_q       <= 64'd0;
      divisor_q  <= 32'd0;
      a_raw_q    <= 32'd0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      bzero_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      sr_q       <= sr_d;
      divisor_q  <= divisor_d;
      a_raw_q    <= a_raw_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      bzero_q    <= bzero_d;
    end
  end

  // Stall, completion pulse and sign-corrected results.
  always_comb begin
    stall_o = ((state_q == DIV_IDLE) && start_i) || (state_q == DIV_ON);
    done_o  = (state_q == DIV_END) && !abort_i;
    if (bzero_q) begin
      quot_o = 32'hFFFF_FFFF;
      rem_o  = a_raw_q;
    end else begin
      quot_o = neg_quot_q ? (~sr_q[31:0] + 32'd1) : sr_q[31:0];
      rem_o  = neg_rem_q ? (~sr_q[63:32] + 32'd1) : sr_q[63:32];
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Execute-stage HI/LO unit: single-cycle multiply and MTHI/MTLO, multi-cycle
// divide via div_radix2, and HI/LO read data for MFHI/MFLO.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  hilo_muldiv_if.slave bus
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] prod_signed_s;
  logic [63:0] prod_unsigned_s;
  logic        div_start_s;
  logic        div_signed_s;
  logic        div_done_s;
  logic [31:0] div_quot_s;
  logic [31:0] div_rem_s;

  assign div_start_s  = is_div_op(bus.alucontrolE) && !bus.flushE;
  assign div_signed_s = (bus.alucontrolE == EXE_DIV_OP);

  div_radix2 u_div (
    .clk      (clk),
    .rst      (rst),
    .start_i  (div_start_s),
    .abort_i  (bus.flushE),
    .signed_i (div_signed_s),
    .a_i      (bus.srcaE),
    .b_i      (bus.srcbE),
    .stall_o  (bus.div_stall),
    .done_o   (div_done_s),
    .quot_o   (div_quot_s),
    .rem_o    (div_rem_s)
  );

  // Full 64-bit products; operands are extended to 64 bits so the low half is exact.
  always_comb begin
    prod_signed_s   = $signed({{32{bus.srcaE[31]}}, bus.srcaE}) *
                      $signed({{32{bus.srcbE[31]}}, bus.srcbE});
    prod_unsigned_s = {32'd0, bus.srcaE} * {32'd0, bus.srcbE};
  end

  // HI/LO update selection; a flush blocks every write, including a finishing divide.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (bus.flushE) begin
      hi_d = hi_q;
      lo_d = lo_q;
    end else if (div_done_s) begin
      hi_d = div_rem_s;
      lo_d = div_quot_s;
    end else begin
      case (bus.alucontrolE)
        EXE_MULT_OP:  {hi_d, lo_d} = prod_signed_s;
        EXE_MULTU_OP: {hi_d, lo_d} = prod_unsigned_s;
        EXE_MTHI_OP:  hi_d = bus.srcaE;
        EXE_MTLO_OP:  lo_d = bus.srcaE;
        default: begin
          hi_d = hi_q;
          lo_d = lo_q;
        end
      endcase
    end
  end

  // HI/LO registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Read port for MFHI/MFLO, straight from the registers.
  always_comb begin
    case (bus.alucontrolE)
      EXE_MFHI_OP: bus.hilo_rdata = hi_q;
      EXE_MFLO_OP: bus.hilo_rdata = lo_q;
      default:     bus.hilo_rdata = 32'd0;
    endcase
  end

  assign bus.hi_o = hi_q;
  assign bus.lo_o = lo_q;

endmodule
